plazer_membuf_arbiter: RTL and testbench

Two-requester burst arbiter placed in front of one port of the 128 x 256-bit dual-port on-chip frame/line memory. Grants the port to one requester at a time, either round-robin or fixed-priority, and holds the grant for a whole burst. During each burst it generates the word addresses itself and routes returned read data to the requester that owns the grant. The memory port is Avalon-MM style: address registered, output unregistered, so read data returns 1 cycle after the address is issued.

---
 rtl/plazer_membuf_arbiter.sv | 174 +++++++++++++++++
 tb/tb_plazer_membuf_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plazer_membuf_arbiter.sv
// Two-requester burst arbiter for one frame/line memory port (Avalon-MM).
// Define PLAZER_ARB_FIXED_PRIO_EN for fixed m0 priority; default is round-robin.
module plazer_membuf_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int AW        = 7,
  parameter int DW        = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     m0_address,
  input  logic [3:0]        m0_burstcount,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DW-1:0]     m0_writedata,
  input  logic [DW/8-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DW-1:0]     m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [AW-1:0]     m1_address,
  input  logic [3:0]        m1_burstcount,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DW-1:0]     m1_writedata,
  input  logic [DW/8-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DW-1:0]     m1_readdata,
  output logic              m1_readdatavalid,
  output logic [AW-1:0]     mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DW-1:0]     mem_writedata,
  output logic [DW/8-1:0]   mem_byteenable,
  output logic              mem_clken,
  input  logic [DW-1:0]     mem_readdata
);

  localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_owner, w_owner_nxt;
  logic          r_last, w_last_nxt;
  logic          r_rdv, w_rdv_nxt;
  logic          r_tag, w_tag_nxt;
  logic [3:0]    r_len, w_len_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_start, w_start_nxt;

  logic          w_req0, w_req1;
  logic          w_win, w_win_rd;
  logic [3:0]    w_win_bc;
  logic [AW-1:0] w_win_addr;
  logic          w_own_wr;
  logic          w_last_beat;
  logic          w_ack, w_cs, w_we;
  logic [AW-1:0] w_acc_addr;

  function automatic logic [3:0] f_clamp(input logic [3:0] b);
    if (b == 4'd0)  return 4'd1;
    if (b > LP_MAX) return LP_MAX;
    return b;
  endfunction

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

`ifdef PLAZER_ARB_FIXED_PRIO_EN
  assign w_win = ~w_req0;
`else
  // m1 wins a tie only when m0 was served last
  assign w_win = (w_req0 & w_req1) ? ~r_last : w_req1;
`endif

  assign w_win_rd    = w_win ? m1_read       : m0_read;
  assign w_win_bc    = w_win ? m1_burstcount : m0_burstcount;
  assign w_win_addr  = w_win ? m1_address    : m0_address;
  assign w_own_wr    = r_owner ? m1_write : m0_write;
  assign w_last_beat = (r_cnt == r_len - 4'd1);
  assign w_acc_addr  = r_start + AW'(r_cnt);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_len_nxt   = r_len;
    w_start_nxt = r_start;
    w_cnt_nxt   = r_cnt;
    w_rdv_nxt   = 1'b0;
    w_tag_nxt   = r_tag;
    w_ack       = 1'b0;
    w_cs        = 1'b0;
    w_we        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          w_owner_nxt = w_win;
          w_last_nxt  = w_win;
          w_len_nxt   = f_clamp(w_win_bc);
          w_start_nxt = w_win_addr;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = w_win_rd ? S_RD : S_WR;
        end
      end
      S_RD: begin
        w_ack     = (r_cnt == 4'd0);
        w_cs      = 1'b1;
        w_rdv_nxt = 1'b1;
        w_tag_nxt = r_owner;
        if (w_last_beat) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_WR: begin
        w_ack = 1'b1;
        if (w_own_wr) begin
          w_cs = 1'b1;
          w_we = 1'b1;
          if (w_last_beat) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_len   <= 4'd1;
      r_start <= '0;
      r_cnt   <= 4'd0;
      r_rdv   <= 1'b0;
      r_tag   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_len   <= w_len_nxt;
      r_start <= w_start_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rdv   <= w_rdv_nxt;
      r_tag   <= w_tag_nxt;
    end
  end

  assign m0_waitrequest   = ~(w_ack & ~r_owner);
  assign m1_waitrequest   = ~(w_ack & r_owner);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = r_rdv & ~r_tag;
  assign m1_readdatavalid = r_rdv & r_tag;

  assign mem_address    = w_cs ? w_acc_addr : '0;
  assign mem_chipselect = w_cs;
  assign mem_write      = w_we;
  assign mem_writedata  = r_owner ? m1_writedata : m0_writedata;
  assign mem_byteenable = r_owner ? m1_byteenable : m0_byteenable;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_plazer_membuf_arbiter.sv
// Randomized bench for plazer_membuf_arbiter with a transaction-level model.
// Honors PLAZER_ARB_FIXED_PRIO_EN when predicting arbitration.
module tb_plazer_membuf_arbiter;

`ifdef PLAZER_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rd [2];
  logic wr [2];
  logic [6:0] ad [2];
  logic [3:0] bc [2];
  logic [255:0] wd [2];
  logic [31:0] be [2];
  logic wq [2];
  logic rv [2];
  logic [255:0] rdat [2];
  logic [6:0] mem_address;
  logic mem_cs, mem_we, mem_clken;
  logic [255:0] mem_wd, mem_rd;
  logic [31:0] mem_be;

  logic [255:0] mem [128];
  logic [255:0] exp_mem [128];
  logic bd_init = 1'b0;
  logic bd_we = 1'b0;
  logic [6:0] bd_addr = '0;
  logic [255:0] bd_data = '0;

  logic [255:0] wtab [2][16];
  logic [31:0] btab [2][16];

  int cyc = 0;
  int viol = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit last;
  int rb0;

  logic [255:0] rq0[$], rq1[$];
  int rc0[$], rc1[$];
  logic [7:0] aq[$];
  int ac[$];

  plazer_membuf_arbiter dut (
    .clk(clk), .reset_n(rst_n),
    .m0_address(ad[0]), .m0_burstcount(bc[0]),
    .m0_read(rd[0]), .m0_write(wr[0]),
    .m0_writedata(wd[0]), .m0_byteenable(be[0]),
    .m0_waitrequest(wq[0]), .m0_readdata(rdat[0]),
    .m0_readdatavalid(rv[0]),
    .m1_address(ad[1]), .m1_burstcount(bc[1]),
    .m1_read(rd[1]), .m1_write(wr[1]),
    .m1_writedata(wd[1]), .m1_byteenable(be[1]),
    .m1_waitrequest(wq[1]), .m1_readdata(rdat[1]),
    .m1_readdatavalid(rv[1]),
    .mem_address(mem_address), .mem_chipselect(mem_cs),
    .mem_write(mem_we), .mem_writedata(mem_wd),
    .mem_byteenable(mem_be), .mem_clken(mem_clken),
    .mem_readdata(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] bmerge(input logic [255:0] o,
                                          input logic [255:0] d,
                                          input logic [31:0] e);
    bmerge = o;
    for (int i = 0; i < 32; i++)
      if (e[i]) bmerge[i*8 +: 8] = d[i*8 +: 8];
  endfunction

  function automatic int tb_len(input logic [3:0] b);
    if (b == 0) return 1;
    if (b > 8) return 8;
    return int'(b);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 256'(i);
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (mem_cs && mem_we) begin
      mem[mem_address] <= bmerge(mem[mem_address], mem_wd, mem_be);
    end
    if (mem_cs) mem_rd <= mem[mem_address];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!wq[0] && !wq[1]) viol <= viol + 1;
      if (rdat[0] !== mem_rd || rdat[1] !== mem_rd) viol <= viol + 1;
      if (mem_clken !== 1'b1) viol <= viol + 1;
      if (rv[0]) begin rq0.push_back(rdat[0]); rc0.push_back(cyc); end
      if (rv[1]) begin rq1.push_back(rdat[1]); rc1.push_back(cyc); end
      if (mem_cs) begin aq.push_back({mem_we, mem_address}); ac.push_back(cyc); end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_burst(input int m, input bit isr, input logic [6:0] a,
                          input logic [3:0] b, input int ga, input int gl,
                          output int acc);
    int n, k, c;
    logic w;
    n = tb_len(b);
    acc = -1;
    ad[m] = a;
    bc[m] = b;
    if (isr) begin
      rd[m] = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk); w = wq[m]; c = cyc;
        @(posedge clk);
        if (!w) begin acc = c; break; end
      end
      #1 rd[m] = 1'b0;
      if (acc < 0) chk("rd_timeout", 0, 1);
    end else begin
      k = 0;
      wr[m] = 1'b1; wd[m] = wtab[m][0]; be[m] = btab[m][0];
      for (int i = 0; i < 200 && k < n; i++) begin
        @(negedge clk); w = wq[m]; c = cyc;
        @(posedge clk); #1;
        if (!w && wr[m]) begin
          if (k == 0) acc = c;
          k++;
          if (k < n) begin
            if (k - 1 == ga && gl > 0) begin
              wr[m] = 1'b0;
              repeat (gl) @(posedge clk);
              #1 wr[m] = 1'b1;
            end
            wd[m] = wtab[m][k]; be[m] = btab[m][k];
          end
        end
      end
      wr[m] = 1'b0;
      if (k < n) chk("wr_timeout", k, n);
    end
  endtask

  task automatic round(input bit u0, input bit u1, input bit r0, input bit r1,
                       input logic [6:0] a0, input logic [6:0] a1,
                       input logic [3:0] b0, input logic [3:0] b1,
                       input int ga0, input int gl0, input int ga1, input int gl1);
    bit rr[2];
    logic [6:0] aa[2];
    logic [3:0] bb[2];
    int ga[2], gl[2], acc[2], ord[2];
    int nop, s, n, ck, m, ba, br0, br1, nb;
    logic [6:0] a;
    logic [7:0] e_acc[$];
    int e_ac[$], e_c0[$], e_c1[$];
    logic [255:0] e_r0[$], e_r1[$];
    rr[0] = r0; rr[1] = r1; aa[0] = a0; aa[1] = a1; bb[0] = b0; bb[1] = b1;
    ga[0] = ga0; ga[1] = ga1; gl[0] = gl0; gl[1] = gl1;
    acc[0] = -1; acc[1] = -1;
    ba = aq.size(); br0 = rq0.size(); br1 = rq1.size();
    rb0 = br0;
    if (u0 && u1) begin
      ord[0] = FIXED ? 0 : (last ? 0 : 1);
      ord[1] = 1 - ord[0];
      nop = 2;
    end else begin
      ord[0] = u0 ? 0 : 1;
      ord[1] = 0;
      nop = 1;
    end
    @(posedge clk); #1;
    s = cyc + 1;
    fork
      begin if (u0) do_burst(0, rr[0], aa[0], bb[0], ga[0], gl[0], acc[0]); end
      begin if (u1) do_burst(1, rr[1], aa[1], bb[1], ga[1], gl[1], acc[1]); end
    join
    repeat (12) @(posedge clk);
    #1;
    for (int j = 0; j < nop; j++) begin
      m = ord[j];
      n = tb_len(bb[m]);
      chk(j == 0 ? "grant_first" : "grant_second", acc[m], s);
      for (int k = 0; k < n; k++) begin
        a = aa[m] + 7'(k);
        ck = s + k + ((!rr[m] && ga[m] >= 0 && k > ga[m]) ? gl[m] : 0);
        e_acc.push_back({~rr[m], a});
        e_ac.push_back(ck);
        if (rr[m] && m == 0) begin e_r0.push_back(exp_mem[a]); e_c0.push_back(ck + 1); end
        if (rr[m] && m == 1) begin e_r1.push_back(exp_mem[a]); e_c1.push_back(ck + 1); end
        if (!rr[m]) exp_mem[a] = bmerge(exp_mem[a], wtab[m][k], btab[m][k]);
      end
      s = s + n + ((!rr[m] && ga[m] >= 0) ? gl[m] : 0) + 1;
      last = (m == 1);
    end
    chk("access_count", aq.size() - ba, e_acc.size());
    foreach (e_acc[i]) begin
      chk("access_addr", aq[ba + i], e_acc[i]);
      chk("access_cycle", ac[ba + i], e_ac[i]);
    end
    chk("m0_rdv_count", rq0.size() - br0, e_r0.size());
    foreach (e_r0[i]) begin
      chk("m0_rdata", rq0[br0 + i], e_r0[i]);
      chk("m0_rdv_cycle", rc0[br0 + i], e_c0[i]);
    end
    chk("m1_rdv_count", rq1.size() - br1, e_r1.size());
    foreach (e_r1[i]) begin
      chk("m1_rdata", rq1[br1 + i], e_r1[i]);
      chk("m1_rdv_cycle", rc1[br1 + i], e_c1[i]);
    end
    nb = 0;
    for (int i = 0; i < 128; i++)
      if (mem[i] !== exp_mem[i]) nb++;
    chk("mem_image", nb, 0);
  endtask

  task automatic fill_tabs();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 16; k++) begin
        wtab[m][k] = {8{$urandom}};
        btab[m][k] = $urandom;
      end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wq0"}, wq[0], 1'b1);
    chk({tag, "_wq1"}, wq[1], 1'b1);
    chk({tag, "_rdv0"}, rv[0], 1'b0);
    chk({tag, "_rdv1"}, rv[1], 1'b0);
    chk({tag, "_cs"}, mem_cs, 1'b0);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_addr"}, mem_address, 7'd0);
    chk({tag, "_clken"}, mem_clken, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] b;
    bit r;
    int ga, gl, n, nr, w0;
    int gq[$];
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      rd[m] = 0; wr[m] = 0; ad[m] = '0; bc[m] = '0; wd[m] = '0; be[m] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    bd_init = 1'b1;
    @(posedge clk); #1;
    bd_init = 1'b0;
    for (int i = 0; i < 128; i++) exp_mem[i] = 256'(i);
    rst_n = 1'b1;
    last = 1'b1;

    fill_tabs();
    round(1, 0, 1, 0, 7'd5, 7'd0, 4'd4, 4'd0, -1, 0, -1, 0);
    for (int k = 0; k < 4; k++) chk("m0_read_5_to_8", rq0[rb0 + k], 256'(5 + k));

    fill_tabs();
    round(0, 1, 0, 0, 7'd0, 7'd126, 4'd0, 4'd3, -1, 0, 0, 1);

    fill_tabs();
    round(1, 1, 1, 0, 7'd40, 7'd50, 4'd0, 4'd15, -1, 0, -1, 0);

    @(posedge clk); #1;
    rd[0] = 1; rd[1] = 1; bc[0] = 4'd1; bc[1] = 4'd1;
    ad[0] = 7'd3; ad[1] = 7'd9;
    repeat (12) begin
      @(negedge clk);
      if (!wq[0]) gq.push_back(0);
      if (!wq[1]) gq.push_back(1);
    end
    @(posedge clk); #1;
    rd[0] = 0; rd[1] = 0;
    w0 = FIXED ? 0 : (last ? 0 : 1);
    chk("cont_grant_count", gq.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("cont_grant_id", gq[i], FIXED ? 0 : (w0 ^ (i & 1)));
    last = FIXED ? 1'b0 : ((w0 ^ 1) == 1);
    repeat (4) @(posedge clk);

    #1;
    bd_addr = 7'd10; bd_data = {256{1'b1}}; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    exp_mem[10] = {256{1'b1}};
    fill_tabs();
    wtab[1][0] = '0;
    btab[1][0] = 32'h0000_0001;
    round(0, 1, 0, 0, 7'd0, 7'd10, 4'd0, 4'd1, -1, 0, -1, 0);
    chk("byteenable_byte0", mem[10], {{31{8'hFF}}, 8'h00});

    @(posedge clk); #1;
    ad[0] = 7'd20; bc[0] = 4'd8; rd[0] = 1;
    @(posedge clk); #1;
    rd[0] = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    nr = rq0.size() + rq1.size();
    #1;
    chk_reset_outs("midreset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    last = 1'b1;
    repeat (10) @(posedge clk);
    chk("no_rdv_after_reset", rq0.size() + rq1.size() - nr, 0);
    fill_tabs();
    round(1, 1, 0, 1, 7'd60, 7'd61, 4'd2, 4'd2, -1, 0, -1, 0);

    for (int t = 0; t < 80; t++) begin
      fill_tabs();
      r = $urandom_range(0, 1);
      b = 4'($urandom_range(0, 15));
      n = tb_len(b);
      ga = -1; gl = 0;
      if (!r && n >= 2 && $urandom_range(0, 1) == 1) begin
        ga = $urandom_range(0, n - 2);
        gl = $urandom_range(1, 2);
      end
      case ($urandom_range(0, 2))
        0: round(1, 0, r, 0, 7'($urandom), 7'd0, b, 4'd0, ga, gl, -1, 0);
        1: round(0, 1, 0, r, 7'd0, 7'($urandom), 4'd0, b, -1, 0, ga, gl);
        default: round(1, 1, r, $urandom_range(0, 1) == 1, 7'($urandom),
                       7'($urandom), b, 4'($urandom_range(0, 15)), ga, gl, -1, 0);
      endcase
    end

    chk("waitrequest_exclusive", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
